// File: rtl/sin_cos.sv
// rtl/sin_cos.sv - registered 10-bit-phase sine/cosine generator, quarter-wave table with quadrant folding
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset, clears both outputs
//   phase    in   10-bit angle, one full turn = 1024
//   sin_val  out  signed 18-bit sin(angle), 17 fractional bits, 1-cycle latency
//   cos_val  out  signed 18-bit cos(angle), 17 fractional bits, 1-cycle latency

module sin_cos (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         phase,
    output logic signed [17:0] sin_val,
    output logic signed [17:0] cos_val
);

    // pi with 60 fractional bits (hex expansion 3.243F6A8885A308D...).
    localparam logic [127:0] PI_FIX = 128'h3243_F6A8_885A_308D;

    // Elaboration-time table entry: round(sin(pi*k/512) * 2^17), clamped to
    // 0x1FFFF. Evaluated with a Taylor series in 60-fractional-bit fixed
    // point so rounding is exact at the 17-bit output resolution. Partial
    // sums stay positive over [0, pi/2], so unsigned arithmetic suffices.
    function automatic logic [16:0] q_entry(input int k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] rnd;
        x    = (PI_FIX * 128'(k)) >> 9;
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if (n[0]) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        // Add half an output LSB then drop 43 bits: round half up, which is
        // half-away-from-zero for these non-negative values.
        rnd = (sum + (128'd1 << 42)) >> 43;
        if (rnd > 128'd131071) begin
            rnd = 128'd131071;
        end
        return rnd[16:0];
    endfunction

    logic [16:0] w_qtab [0:256];

    for (genvar gk = 0; gk <= 256; gk++) begin : g_qtab
        localparam logic [16:0] QV = q_entry(gk);
        assign w_qtab[gk] = QV;
    end

    // Cosine reuses the sine fold with the phase advanced by a quarter turn.
    logic [9:0]  w_cos_phase;
    logic [8:0]  w_sin_idx;
    logic [8:0]  w_cos_idx;
    logic [17:0] w_sin_mag;
    logic [17:0] w_cos_mag;
    logic [17:0] w_sin_next;
    logic [17:0] w_cos_next;

    assign w_cos_phase = phase + 10'd256;

    // Odd quadrants run the table backwards; index 256 is reachable only
    // there (offset 0 in quadrants 1 and 3).
    assign w_sin_idx = phase[8] ? (9'd256 - {1'b0, phase[7:0]})
                                : {1'b0, phase[7:0]};
    assign w_cos_idx = w_cos_phase[8] ? (9'd256 - {1'b0, w_cos_phase[7:0]})
                                      : {1'b0, w_cos_phase[7:0]};

    assign w_sin_mag = {1'b0, w_qtab[w_sin_idx]};
    assign w_cos_mag = {1'b0, w_qtab[w_cos_idx]};

    // Lower half-turn negates. Magnitudes never exceed 0x1FFFF, so the
    // result stays within -131071..+131071 and -0 folds to 0.
    assign w_sin_next = phase[9]       ? (18'd0 - w_sin_mag) : w_sin_mag;
    assign w_cos_next = w_cos_phase[9] ? (18'd0 - w_cos_mag) : w_cos_mag;

    logic signed [17:0] r_sin;
    logic signed [17:0] r_cos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sin <= '0;
            r_cos <= '0;
        end else begin
            r_sin <= w_sin_next;
            r_cos <= w_cos_next;
        end
    end

    assign sin_val = r_sin;
    assign cos_val = r_cos;

endmodule

// File: tb/tb_sin_cos.sv
// tb/tb_sin_cos.sv - self-checking bench for sin_cos against a real-arithmetic reference

module tb_sin_cos;

    logic               clk;
    logic               rst_n;
    logic [9:0]         phase;
    logic signed [17:0] sin_val;
    logic signed [17:0] cos_val;

    int n_checks = 0;
    int n_fail   = 0;

    int sweep_sin [0:1023];

    sin_cos dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase   (phase),
        .sin_val (sin_val),
        .cos_val (cos_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round(f(2*pi*p/1024) * 2^17) half away from zero, clamped.
    function automatic int ref_val(input int p, input bit is_cos);
        real a;
        real v;
        real r;
        a = 2.0 * 3.14159265358979323846 * real'(p % 1024) / 1024.0;
        v = (is_cos ? $cos(a) : $sin(a)) * 131072.0;
        r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
        if (r > 131071.0)  r = 131071.0;
        if (r < -131071.0) r = -131071.0;
        return $rtoi(r);
    endfunction

    task automatic chk(input string tag, input int p, input logic [17:0] obs, input int exp);
        logic [17:0] e;
        e = 18'(exp);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s phase=%0d observed=%0d required=%0d", tag, p, $signed(obs), $signed(e));
        end
    endtask

    // Present a phase, let it be sampled on the next rising edge, then check
    // 1 time unit later.
    task automatic step_check(input int p, input string tag);
        phase = 10'(p);
        @(posedge clk);
        #1;
        chk({tag, "_sin"}, p, sin_val, ref_val(p, 1'b0));
        chk({tag, "_cos"}, p, cos_val, ref_val(p, 1'b1));
    endtask

    int dir_p   [8] = '{0,      128,   256,     512,     768,     1,      1023,   384};
    int dir_sin [8] = '{0,      92682, 131071,  0,       -131071, 804,    -804,   92682};
    int dir_cos [8] = '{131071, 92682, 0,       -131071, 0,       131070, 131070, -92682};

    initial begin
        rst_n = 1'b1;
        phase = 10'd300;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_sin", 300, sin_val, 0);
        chk("reset_cos", 300, cos_val, 0);
        @(posedge clk);
        #1;
        chk("reset_hold_sin", 300, sin_val, 0);
        chk("reset_hold_cos", 300, cos_val, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed points with spec-given constants.
        for (int i = 0; i < 8; i++) begin
            phase = 10'(dir_p[i]);
            @(posedge clk);
            #1;
            chk("dir_sin", dir_p[i], sin_val, dir_sin[i]);
            chk("dir_cos", dir_p[i], cos_val, dir_cos[i]);
        end

        // Full sweep, a new phase every cycle.
        for (int p = 0; p < 1024; p++) begin
            step_check(p, "sweep");
            sweep_sin[p] = int'(sin_val);
        end
        // Wrap 1023 -> 0 without reset.
        step_check(0, "wrap");

        // Half-turn antisymmetry over the captured sweep.
        for (int p = 0; p < 512; p++) begin
            chk("antisym", p, 18'(sweep_sin[p]), -sweep_sin[p + 512]);
        end

        // Random phases.
        for (int i = 0; i < 200; i++) begin
            step_check(int'($urandom_range(1023, 0)), "rand");
        end

        // Constant phase holds outputs.
        step_check(77, "hold0");
        step_check(77, "hold1");

        // Asynchronous reset mid-stream, between edges.
        step_check(200, "pre_rst");
        phase = 10'd600;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sin", 600, sin_val, 0);
        chk("async_rst_cos", 600, cos_val, 0);
        @(posedge clk);
        #1;
        chk("in_rst_sin", 600, sin_val, 0);
        chk("in_rst_cos", 600, cos_val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("released_sin", 600, sin_val, 0);
        chk("released_cos", 600, cos_val, 0);
        step_check(600, "post_rst");
        step_check(int'($urandom_range(1023, 0)), "post_rst_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sin_cos.md
# sin_cos

Registered sine/cosine generator for the arcade template's rotation math (ship and asteroid heading vectors). It maps a 10-bit phase covering one full turn to signed 18-bit sine and cosine values. Values are fixed-point with 17 fractional bits, so a value of 131072 represents 1.0. Internally it uses a single quarter-wave lookup table with quadrant folding, followed by one output register stage.

## Interface
Parameters:
- none (widths fixed: phase 10 bits, outputs 18 bits)

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- phase  input  10  angle; angle = 2*pi*phase/1024; unsigned, wraps modulo 1024
- sin_val  output  18  signed two's complement sin(angle), scaled by 2^17
- cos_val  output  18  signed two's complement cos(angle), scaled by 2^17

## Operation
- Quarter table Q[k], k = 0..256, holds round(sin(2*pi*k/1024) * 131072), with round-half-away-from-zero.
  - Q[0] = 0.
  - Q[256] saturates to 131071 (0x1FFFF), because +1.0 is not representable.
  - All entries are non-negative and at most 17 bits of magnitude.
- Folding of a phase p, with quadrant q = p[9:8] and offset k = p[7:0]:
  - q=0: s = +Q[k]
  - q=1: s = +Q[256-k]
  - q=2: s = -Q[k]
  - q=3: s = -Q[256-k]
- sin_val = s(phase).
- cos_val = s((phase + 256) mod 1024). It uses the same folding function with the phase offset by a quarter turn. No separate cosine table.
- Negation is two's complement in 18 bits.
  - -0 yields 0.
  - -Q[256] yields -131071 (0x20001).
  - -131072 is never produced, so the output range is symmetric: -131071..+131071.
- Wrap-around: phase 1023 to 0 is continuous, with no special case.
- Pure function of phase. There is no other state beyond the output registers.

## Timing
- Latency is 1 cycle.
  - phase is sampled on rising edge N.
  - sin_val and cos_val for that phase are valid after edge N and hold until edge N+1.
- The table lookup, folding and negation are combinational between phase and the output registers.
- Throughput: a new phase is accepted every cycle, with no handshake.
- Reset:
  - While rst_n = 0, both sin_val and cos_val are 0, immediately and asynchronously.
  - The first update after release happens on the first rising edge with rst_n = 1.
- Reset asserted mid-stream: outputs go to 0 at once. The sample in progress is discarded.
- Holding phase constant keeps the outputs constant.

## Test plan
- phase=0 -> sin_val=0x00000 (0), cos_val=0x1FFFF (131071), one cycle after sampling.
- phase=128 -> sin_val=cos_val=92682 (0x16A0A). phase=256 -> sin_val=131071, cos_val=0.
- phase=512 -> sin_val=0, cos_val=0x20001 (-131071). phase=768 -> sin_val=-131071 (0x20001), cos_val=0.
- phase=1 -> sin_val=804, cos_val=131070. phase=1023 -> sin_val=-804 (0x3FCDC), cos_val=131070.
- Sweep phase 0..1023 with a new value every cycle:
  - Each output equals round(sin/cos(2*pi*p/1024) * 131072), clamped to ±131071, within ±0 LSB.
  - Each result appears exactly one cycle after its phase is sampled.
  - sin(p) = -sin(p+512) for all p.
- Assert rst_n=0 asynchronously mid-sweep, between clock edges -> both outputs read 0 immediately. Release -> correct values after the next rising edge.
